// File: rtl/key_entry_controller.sv
// PS/2 scancode sequencer: assembles hex-digit make codes into a fixed-length key.
// Optional build macro KEY_REPEAT_FILTER_EN suppresses typematic repeats of the same make code.
module key_entry_controller #(
    parameter int DIGITS  = 4,
    parameter int TIMEOUT = 20000
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic                           code_valid,
    input  logic [7:0]                     code,
    output logic [4*DIGITS-1:0]            key_out,
    output logic                           key_ready,
    output logic [$clog2(DIGITS+1)-1:0]    digit_count,
    output logic                           entry_error
);

    localparam int KW = 4 * DIGITS;
    localparam int CW = $clog2(DIGITS + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_ENTER = 8'h5A;
    localparam logic [7:0] SC_BKSP  = 8'h66;
    localparam logic [7:0] SC_ESC   = 8'h76;

    typedef enum logic [1:0] {
        IDLE,
        BRK,
        EXT,
        EXT_BRK
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [TW-1:0]   timer;
    logic [KW-1:0]   buffer;

    logic            make_evt;
    logic            ext_enter;
    logic            brk_done;
    logic            timeout_hit;
    logic            make_act;
    logic [4:0]      nib_hit;
    logic            is_digit;
    logic            is_enter;
    logic            is_bksp;
    logic            is_esc;
    logic            full;

    // {hit, nibble} for hex-digit make codes; hit=0 for everything else.
    function automatic logic [4:0] hex_nibble(input logic [7:0] c);
        logic [4:0] r;
        r = '0;
        case (c)
            8'h45: r = {1'b1, 4'h0};
            8'h16: r = {1'b1, 4'h1};
            8'h1E: r = {1'b1, 4'h2};
            8'h26: r = {1'b1, 4'h3};
            8'h25: r = {1'b1, 4'h4};
            8'h2E: r = {1'b1, 4'h5};
            8'h36: r = {1'b1, 4'h6};
            8'h3D: r = {1'b1, 4'h7};
            8'h3E: r = {1'b1, 4'h8};
            8'h46: r = {1'b1, 4'h9};
            8'h1C: r = {1'b1, 4'hA};
            8'h32: r = {1'b1, 4'hB};
            8'h21: r = {1'b1, 4'hC};
            8'h23: r = {1'b1, 4'hD};
            8'h24: r = {1'b1, 4'hE};
            8'h2B: r = {1'b1, 4'hF};
            default: r = '0;
        endcase
        return r;
    endfunction

    assign timeout_hit = (state != IDLE) && (timer == TW'(TIMEOUT - 1));

    // ---------------- prefix FSM ----------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A strobe always wins over a simultaneous timeout expiry.
    always_comb begin
        state_nxt = state;
        make_evt  = 1'b0;
        ext_enter = 1'b0;
        brk_done  = 1'b0;
        if (code_valid) begin
            case (state)
                IDLE: begin
                    if (code == SC_BREAK) begin
                        state_nxt = BRK;
                    end else if (code == SC_EXT) begin
                        state_nxt = EXT;
                    end else begin
                        make_evt = 1'b1;
                    end
                end
                BRK: begin
                    brk_done  = 1'b1;
                    state_nxt = IDLE;
                end
                EXT: begin
                    if (code == SC_BREAK) begin
                        state_nxt = EXT_BRK;
                    end else begin
                        ext_enter = (code == SC_ENTER);
                        state_nxt = IDLE;
                    end
                end
                EXT_BRK: begin
                    brk_done  = 1'b1;
                    state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end else if (timeout_hit) begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            timer <= '0;
        end else if (code_valid || timeout_hit || state == IDLE) begin
            timer <= '0;
        end else begin
            timer <= timer + 1'b1;
        end
    end

    // ---------------- typematic repeat filter ----------------
`ifdef KEY_REPEAT_FILTER_EN
    logic [7:0] last_make;

    always_ff @(posedge CLK) begin
        if (RST) begin
            last_make <= '0;
        end else if (brk_done || (!code_valid && timeout_hit)) begin
            last_make <= '0;
        end else if (make_evt) begin
            last_make <= code;
        end
    end

    assign make_act = make_evt && (code != last_make);
`else
    assign make_act = make_evt;
`endif

    // ---------------- key decode ----------------
    always_comb begin
        nib_hit  = hex_nibble(code);
        is_digit = make_act && nib_hit[4];
        is_enter = (make_act && code == SC_ENTER) || ext_enter;
        is_bksp  = make_act && code == SC_BKSP;
        is_esc   = make_act && code == SC_ESC;
        full     = (digit_count == CW'(DIGITS));
    end

    // ---------------- edit buffer and outputs ----------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            buffer      <= '0;
            digit_count <= '0;
            key_out     <= '0;
            key_ready   <= 1'b0;
            entry_error <= 1'b0;
        end else begin
            key_ready   <= 1'b0;
            entry_error <= 1'b0;
            if (is_digit) begin
                if (!full) begin
                    buffer      <= (buffer << 4) | KW'(nib_hit[3:0]);
                    digit_count <= digit_count + 1'b1;
                end else begin
                    entry_error <= 1'b1;
                end
            end else if (is_enter) begin
                if (full) begin
                    key_out     <= buffer;
                    key_ready   <= 1'b1;
                    buffer      <= '0;
                    digit_count <= '0;
                end else begin
                    entry_error <= 1'b1;
                end
            end else if (is_bksp) begin
                if (digit_count != '0) begin
                    buffer      <= buffer >> 4;
                    digit_count <= digit_count - 1'b1;
                end
            end else if (is_esc) begin
                buffer      <= '0;
                digit_count <= '0;
            end
        end
    end

endmodule
